// File: rtl/eight_way_rr_arbiter.sv
// Eight-way round-robin arbiter with a bounded hold time.
// Grant, index and valid are registered outputs.
module eight_way_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);

  state_t     state;
  logic [2:0] last;
  logic [3:0] hold_cnt;

  logic [7:0] cand;
  logic [2:0] win;
  logic [2:0] k;
  logic       found;
  logic       others;
  logic       keep;

  // The holder is always 'last' while in GRANT, so it is masked out.
  always_comb begin
    cand   = (state == GRANT) ? (req & ~grant) : req;
    others = |(req & ~grant);
    keep   = req[grant_idx] &&
             ((hold_cnt < HOLD_MAX) || !others);
    win    = 3'd0;
    k      = 3'd0;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      k = last + 3'(i);
      if (!found && cand[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 3'd7;
      hold_cnt    <= 4'd0;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      hold_cnt    <= 4'd0;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state       <= GRANT;
            last        <= win;
            hold_cnt    <= 4'd0;
            grant       <= 8'h01 << win;
            grant_idx   <= win;
            grant_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (keep) begin
            if (hold_cnt < HOLD_MAX)
              hold_cnt <= hold_cnt + 4'd1;
          end else if (found) begin
            last        <= win;
            hold_cnt    <= 4'd0;
            grant       <= 8'h01 << win;
            grant_idx   <= win;
            grant_valid <= 1'b1;
          end else begin
            state       <= IDLE;
            hold_cnt    <= 4'd0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_way_rr_arbiter.sv
// Directed bench for eight_way_rr_arbiter.
// Two instances: hold limit 4 and hold limit 1.
module tb_eight_way_rr_arbiter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] req;

  logic [7:0] g4;
  logic [2:0] i4;
  logic       v4;
  logic [7:0] g1;
  logic [2:0] i1;
  logic       v1;

  int checks;
  int failures;

  eight_way_rr_arbiter #(.MAX_HOLD(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .grant(g4), .grant_idx(i4), .grant_valid(v4)
  );

  eight_way_rr_arbiter #(.MAX_HOLD(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .grant(g1), .grant_idx(i1), .grant_valid(v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = 8'h00;
    enable = 1'b1;
    step();
    reset  = 1'b0;
  endtask

  initial begin
    logic [7:0] seq2 [10];
    logic [2:0] seq3 [12];
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    req      = 8'h00;
    #1;
    check("rst_grant", 32'(g4), 32'h00);
    check("rst_idx",   32'(i4), 32'h0);
    check("rst_valid", 32'(v4), 32'h0);
    step();
    reset = 1'b0;

    // 1: async reset mid-grant, then first grant goes to 0
    req    = 8'h08;
    enable = 1'b1;
    step();
    check("t1_hold3",  32'(g4), 32'h08);
    check("t1_idx3",   32'(i4), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("t1_async_g", 32'(g4), 32'h00);
    check("t1_async_v", 32'(v4), 32'h0);
    step();
    req   = 8'hFF;
    reset = 1'b0;
    step();
    check("t1_first_g", 32'(g4), 32'h01);
    check("t1_first_i", 32'(i4), 32'h0);

    // 2: round-robin wrap with hold limit 1
    seq2 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
             8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    for (int n = 0; n < 10; n++) begin
      if (n > 0) step();
      check($sformatf("t2_rr%0d", n), 32'(g1), 32'(seq2[n]));
    end

    // 3: hold limit 4 between requesters 0 and 2
    do_reset();
    req  = 8'h05;
    seq3 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2,
             3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int n = 0; n < 12; n++) begin
      step();
      check($sformatf("t3_idx%0d", n), 32'(i4), 32'(seq3[n]));
      check($sformatf("t3_g%0d", n), 32'(g4),
            32'h1 << seq3[n]);
    end

    // 4: sole holder never preempted, then release to idle
    do_reset();
    req = 8'h20;
    for (int n = 0; n < 20; n++) begin
      step();
      check($sformatf("t4_hold%0d", n), 32'(g4), 32'h20);
    end
    check("t4_u1_hold", 32'(g1), 32'h20);
    req = 8'h00;
    step();
    check("t4_rel_g", 32'(g4), 32'h00);
    check("t4_rel_v", 32'(v4), 32'h0);
    check("t4_rel_i", 32'(i4), 32'h0);

    // 5: same-cycle handoff without a bubble
    do_reset();
    req = 8'h40;
    step();
    check("t5_h6", 32'(g4), 32'h40);
    req = 8'h02;
    step();
    check("t5_hand_g", 32'(g4), 32'h02);
    check("t5_hand_v", 32'(v4), 32'h1);
    check("t5_hand_i", 32'(i4), 32'h1);

    // 6: enable gating keeps the pointer
    do_reset();
    req = 8'h10;
    step();
    check("t6_h4", 32'(g4), 32'h10);
    enable = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("t6_off_g%0d", n), 32'(g4), 32'h00);
      check($sformatf("t6_off_v%0d", n), 32'(v4), 32'h0);
    end
    enable = 1'b1;
    req    = 8'h11;
    step();
    check("t6_wrap_i", 32'(i4), 32'h0);
    check("t6_wrap_g", 32'(g4), 32'h01);
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("t6_keep%0d", n), 32'(g4), 32'h01);
    end
    step();
    check("t6_next_i", 32'(i4), 32'h4);
    check("t6_next_g", 32'(g4), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eight_way_rr_arbiter.md
Name: eight_way_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Drives a registered one-hot 8-bit grant, matching the 3-to-8 decoder output format, plus the encoded 3-bit winner index.
- Sits in front of the shared resource as its sequencer.
- Bounds how long one requester may hold the grant while others wait.

Parameters:
- MAX_HOLD, 4: maximum consecutive granted cycles for one holder while any other request is pending. Legal range is 1..15.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  arbiter enable. When low, no grant is issued.
- req  input  8  request vector; bit i is requester i.
- grant  output  8  registered one-hot grant; all-zero when no grant.
- grant_idx  output  3  registered binary index of the current holder; 0 when no grant.
- grant_valid  output  1  registered; high when grant is non-zero.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - grant=8'h00, grant_idx=3'd0, grant_valid=0.
  - State IDLE, hold_cnt=0, last pointer=3'd7, so requester 0 has first priority after reset.
- All outputs are registered. The grant appears 1 cycle after the qualifying req/enable edge; there is no combinational path from req to grant.
- RR winner selection:
  - Search starts at (last+1) mod 8 and moves upward with wrap-around.
  - The first set bit of req wins.
  - last updates to the winner index whenever a new grant is issued.
- State machine (2 states):
  - IDLE:
    - If enable=1 and req!=0: next state GRANT, grant = one-hot of winner, grant_idx = winner, grant_valid=1, hold_cnt=0.
    - Otherwise remain IDLE with outputs zero.
  - GRANT, holder h:
    - Continue: req[h]=1 AND (hold_cnt < MAX_HOLD-1 OR no other req bit set). Hold the grant; hold_cnt increments, saturating at MAX_HOLD-1.
    - Release: req[h]=0. If other requests are pending, grant the next RR winner on the next cycle with no idle bubble, and reset hold_cnt to 0. If none are pending, go to IDLE and zero the outputs next cycle.
    - Preempt: req[h]=1, hold_cnt = MAX_HOLD-1, and another req is pending. The grant moves to the RR winner excluding h next cycle; hold_cnt resets to 0.
    - A sole requester is never preempted; it holds indefinitely.
- enable deasserted in any state:
  - Next cycle the outputs are zero and the state is IDLE.
  - last is retained; hold_cnt is cleared.
  - On re-enable, arbitration resumes from last+1.
- Simultaneous events:
  - Holder drops req in the same cycle a new req rises: the release rule applies and the new requester is eligible.
  - Multiple new requests in one cycle are resolved purely by RR order.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant_idx always encodes grant.
  - grant_valid == |grant.
  - A granted bit always had req=1 in the cycle before.
- Fairness: with all 8 requesting continuously and MAX_HOLD=1, the grant order is 0,1,2,...,7,0,... with each requester granted exactly once per 8 cycles.

Test Plan:
1. Reset: assert reset mid-grant (holder 3) between clock edges → grant=00, grant_valid=0 immediately. After release with req=8'hFF, enable=1, the first grant is 8'h01, idx 0, one cycle after the release edge.
2. Round-robin wrap: MAX_HOLD=1, req=8'hFF held for 10 cycles → grant sequence 01,02,04,08,10,20,40,80,01,02.
3. Hold limit: MAX_HOLD=4, req=8'h05 steady → idx 0 held 4 cycles, then idx 2 for 4 cycles, then idx 0, repeating.
4. Sole holder and release: req=8'h20 only → grant=8'h20 held 20 cycles with no preemption. When req drops to 0, grant=00 and grant_valid=0 the next cycle.
5. Back-to-back handoff: holder 6 drops its req in the same cycle req[1] rises → next cycle grant=8'h02 with no zero cycle in between.
6. Enable gating: holder 4 active, enable=0 for 3 cycles → outputs zero after 1 cycle. On re-enable with req=8'h11 → grant goes to idx 0 (search starts at 5 and wraps) before idx 4.
